sram_req_arbiter: RTL and testbench

Sequencing arbiter in front of the single-port 256x8 SRAM. It shares the SRAM between NUM_REQ requesters, each with a valid/ready request channel. It grants one request at a time and drives the SRAM command pins for exactly one cycle. For reads, it captures the SRAM's registered read data and returns it with a one-cycle response pulse to the owning requester.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/req_prio_pick.sv | 30 +++
 rtl/sram_req_arbiter.sv | 110 +++++++++++
 tb/tb_sram_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM request arbiter.
// Optional feature macro: SRAM_ARB_RR_EN (round-robin priority).
package sram_arb_pkg;

   localparam int unsigned AW_DEF = 8;
   localparam int unsigned DW_DEF = 8;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/req_prio_pick.sv
// One-hot winner pick from a valid vector, searching upward from a start pointer.
module req_prio_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      idx,
   output logic               any
);

   // First valid requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      logic [IW-1:0] cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IW'((32'(ptr) + i) % NUM_REQ);
         if (!any && valid[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbiter sharing one single-port SRAM between NUM_REQ valid/ready requesters.
// Define SRAM_ARB_RR_EN for round-robin priority; otherwise lowest index wins.
module sram_req_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned DW      = DW_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ-1:0]         req_rw,
   input  logic [NUM_REQ-1:0][AW-1:0] req_addr,
   input  logic [NUM_REQ-1:0][DW-1:0] req_wdata,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [DW-1:0]              rsp_rdata,
   output logic                       mem_rw,
   output logic [AW-1:0]              mem_addr,
   output logic [DW-1:0]              mem_din,
   input  logic [DW-1:0]              mem_dout,
   output logic                       busy
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   arb_state_t           state;
   logic                 cmd_rw;
   logic [IW-1:0]        cmd_idx;
   logic [IW-1:0]        ptr;
   logic [NUM_REQ-1:0]   grant;
   logic [IW-1:0]        win_idx;
   logic                 any;
   logic                 accept;

   req_prio_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (any)
   );

   // Acceptance happens only in IDLE, and never while reset is held.
   assign accept    = (state == IDLE) && any && !rst;
   assign req_ready = accept ? grant : '0;
   assign busy      = (state != IDLE);

`ifdef SRAM_ARB_RR_EN
   logic [IW-1:0] last_grant;

   // Remember the most recent winner so the search starts just after it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= IW'(NUM_REQ - 1);
      end else if (accept) begin
         last_grant <= win_idx;
      end
   end

   assign ptr = (last_grant == IW'(NUM_REQ - 1)) ? '0 : last_grant + IW'(1);
`else
   assign ptr = '0;
`endif

   // Sequencer: latch the command, drive the SRAM for one cycle, return read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cmd_rw    <= RW_READ;
         cmd_idx   <= '0;
         mem_rw    <= RW_READ;
         mem_addr  <= '0;
         mem_din   <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= '0;
         mem_rw    <= RW_READ;
         case (state)
            IDLE: begin
               if (any) begin
                  cmd_idx  <= win_idx;
                  cmd_rw   <= req_rw[win_idx];
                  mem_rw   <= req_rw[win_idx];
                  mem_addr <= req_addr[win_idx];
                  mem_din  <= req_wdata[win_idx];
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               state <= (cmd_rw == RW_WRITE) ? IDLE : CAPT;
            end
            CAPT: begin
               rsp_rdata          <= mem_dout;
               rsp_valid[cmd_idx] <= 1'b1;
               state              <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed self-checking bench for sram_req_arbiter with a behavioural 256x8 SRAM.
module tb_sram_req_arbiter;

   logic             clk;
   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_rw;
   logic [1:0][7:0]  req_addr;
   logic [1:0][7:0]  req_wdata;
   logic [1:0]       rsp_valid;
   logic [7:0]       rsp_rdata;
   logic             mem_rw;
   logic [7:0]       mem_addr;
   logic [7:0]       mem_din;
   logic [7:0]       mem_dout;
   logic             busy;

   logic [7:0]       sram [256];
   logic             wipe;
   int               n_chk;
   int               n_fail;
   int               acc1;

   sram_req_arbiter #(
      .NUM_REQ (2),
      .AW      (8),
      .DW      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_rw    (mem_rw),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: write when rw=1, otherwise registered read of the addressed word.
   always @(posedge clk) begin
      if (wipe) begin
         for (int i = 0; i < 256; i++) sram[i] <= 8'h00;
      end else if (mem_rw) begin
         sram[mem_addr] <= mem_din;
      end else begin
         mem_dout <= sram[mem_addr];
      end
   end

   // Count accepts seen by requester 1.
   always @(posedge clk) begin
      if (!rst && req_valid[1] && req_ready[1]) acc1 = acc1 + 1;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Present a request, wait for its accept, then drop valid in the ISSUE cycle.
   task automatic accept(input int idx, input logic rw, input logic [7:0] addr,
                         input logic [7:0] wd, input string tag);
      int n;
      req_valid[idx] = 1'b1;
      req_rw[idx]    = rw;
      req_addr[idx]  = addr;
      req_wdata[idx] = wd;
      #1;
      n = 0;
      while (!req_ready[idx] && n < 10) begin
         tick();
         #1;
         n++;
      end
      check({tag, "_ready"}, 32'(req_ready), 32'(1) << idx);
      tick();
      req_valid[idx] = 1'b0;
   endtask

   task automatic wr(input int idx, input logic [7:0] addr, input logic [7:0] d,
                     input string tag);
      accept(idx, 1'b1, addr, d, tag);
      #1;
      check({tag, "_mem_rw"}, 32'(mem_rw), 32'(1));
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr));
      check({tag, "_mem_din"}, 32'(mem_din), 32'(d));
      tick();
   endtask

   task automatic rd(input int idx, input logic [7:0] addr, input logic [7:0] exp,
                     input string tag);
      accept(idx, 1'b0, addr, 8'h00, tag);
      #1;
      check({tag, "_mem_rw"}, 32'(mem_rw), 32'(0));
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr));
      tick();
      check({tag, "_capt_busy"}, 32'(busy), 32'(1));
      check({tag, "_no_early_rsp"}, 32'(rsp_valid), 32'(0));
      tick();
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1) << idx);
      check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(exp));
   endtask

   initial begin
      int f;
      int s;
      int a1;
      logic [7:0] fa;
      logic [7:0] sa;
      logic [7:0] fd;
      logic [7:0] sd;

      n_chk     = 0;
      n_fail    = 0;
      acc1      = 0;
      rst       = 1'b1;
      wipe      = 1'b1;
      req_valid = '0;
      req_rw    = '0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset state.
      tick();
      tick();
      check("rst_ready", 32'(req_ready), 32'(0));
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
      check("rst_mem_rw", 32'(mem_rw), 32'(0));
      check("rst_mem_addr", 32'(mem_addr), 32'(0));
      check("rst_mem_din", 32'(mem_din), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      wipe = 1'b0;
      rst  = 1'b0;
      tick();

      // Single write then read on requester 0.
      wr(0, 8'h3C, 8'hA5, "w3c");
      check("w3c_idle_mem_rw", 32'(mem_rw), 32'(0));
      check("w3c_idle_busy", 32'(busy), 32'(0));
      rd(0, 8'h3C, 8'hA5, "r3c");

      // Prepare contention data; the last grant before contention goes to requester 0.
      wr(0, 8'h20, 8'hC3, "w20");
      wr(0, 8'h10, 8'h5A, "w10");

      // Contention: both read in the same cycle, requester 1 held until served.
`ifdef SRAM_ARB_RR_EN
      f = 1; s = 0;
`else
      f = 0; s = 1;
`endif
      fa = (f == 0) ? 8'h10 : 8'h20;
      sa = (s == 0) ? 8'h10 : 8'h20;
      fd = (f == 0) ? 8'h5A : 8'hC3;
      sd = (s == 0) ? 8'h5A : 8'hC3;
      a1 = acc1;
      req_rw       = 2'b00;
      req_addr[0]  = 8'h10;
      req_addr[1]  = 8'h20;
      req_valid    = 2'b11;
      #1;
      check("cont_first_ready", 32'(req_ready), 32'(1) << f);
      tick();
      req_valid[f] = 1'b0;
      #1;
      check("cont_issue_ready", 32'(req_ready), 32'(0));
      check("cont_first_addr", 32'(mem_addr), 32'(fa));
      tick();
      check("cont_capt_ready", 32'(req_ready), 32'(0));
      tick();
      check("cont_first_rsp", 32'(rsp_valid), 32'(1) << f);
      check("cont_first_data", 32'(rsp_rdata), 32'(fd));
      check("cont_second_ready", 32'(req_ready), 32'(1) << s);
      tick();
      req_valid[s] = 1'b0;
      #1;
      check("cont_second_addr", 32'(mem_addr), 32'(sa));
      check("cont_rsp_cleared", 32'(rsp_valid), 32'(0));
      tick();
      tick();
      check("cont_second_rsp", 32'(rsp_valid), 32'(1) << s);
      check("cont_second_data", 32'(rsp_rdata), 32'(sd));
      check("hold_req1_once", 32'(acc1 - a1), 32'(1));

      // Back-to-back writes from requester 1: ready every second cycle.
      tick();
      req_rw[1]    = 1'b1;
      req_valid[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr[1]  = 8'(i);
         req_wdata[1] = 8'(8'h40 + i);
         #1;
         check("b2b_ready", 32'(req_ready), 32'(2));
         tick();
         #1;
         check("b2b_gap", 32'(req_ready), 32'(0));
         check("b2b_mem_addr", 32'(mem_addr), 32'(i));
         check("b2b_mem_rw", 32'(mem_rw), 32'(1));
         tick();
      end
      req_valid[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd(0, 8'(i), 8'(8'h40 + i), "b2b_rb");
      end

      // Read-after-write across requesters, then the top address.
      wr(0, 8'h7F, 8'h11, "raw_w");
      rd(1, 8'h7F, 8'h11, "raw_r");
      wr(1, 8'hFF, 8'hEE, "wff");
      rd(0, 8'hFF, 8'hEE, "rff");

      // Reset during the ISSUE cycle of a read.
      accept(0, 1'b0, 8'h3C, 8'h00, "rst_rd");
      rst          = 1'b1;
      req_valid[0] = 1'b1;
      #1;
      check("mid_rst_mem_rw", 32'(mem_rw), 32'(0));
      check("mid_rst_mem_addr", 32'(mem_addr), 32'(0));
      check("mid_rst_mem_din", 32'(mem_din), 32'(0));
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_rdata", 32'(rsp_rdata), 32'(0));
      check("mid_rst_ready", 32'(req_ready), 32'(0));
      req_valid[0] = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_no_rsp", 32'(rsp_valid), 32'(0));
         check("post_rst_idle", 32'(busy), 32'(0));
      end
      rd(0, 8'h55, 8'h00, "post_rst_rd");

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
